// File: rtl/filt_ppi_pkg.sv
// -----------------------------------------------------------------------------
// filt_ppi_pkg
// Shared types and helpers for the polyphase interpolation sequencing
// controller (filt_ppi_ctrl) and its input FIFO (filt_ppi_ctrl_fifo).
//   ppi_state_e    : controller state (IDLE, RUN, STARVE)
//   f_clog2        : ceiling log2, used to size phase, pointer and level fields
//   f_first_phase  : commutator phase that carries the load strobe
//   f_last_phase   : commutator phase at which a frame boundary is evaluated
// -----------------------------------------------------------------------------
package filt_ppi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STARVE = 2'd2
  } ppi_state_e;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int f_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // First phase of a frame: 0 for ascending rotation, L-1 for descending.
  function automatic int f_first_phase(input int l, input int ccw);
    return (ccw != 0) ? (l - 1) : 0;
  endfunction

  // Last phase of a frame: L-1 for ascending rotation, 0 for descending.
  function automatic int f_last_phase(input int l, input int ccw);
    return (ccw != 0) ? 0 : (l - 1);
  endfunction

endpackage

// File: rtl/filt_ppi_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// filt_ppi_ctrl_fifo
// Small synchronous FIFO buffering input samples for the polyphase controller.
// Read data is the head entry (valid while o_empty is low); a sample written
// this cycle becomes visible at the head on the next cycle.
// Ports:
//   i_clk, i_rst_an : clock, synchronous active-low reset
//   i_push, i_wdata : write strobe and data
//   i_pop           : remove head entry
//   o_rdata         : head entry
//   o_full, o_empty : occupancy flags
//   o_level         : number of stored entries (0..gp_depth)
// -----------------------------------------------------------------------------
module filt_ppi_ctrl_fifo
  import filt_ppi_pkg::*;
#(
  parameter int gp_width = 16,
  parameter int gp_depth = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst_an,
  input  logic                              i_push,
  input  logic [gp_width-1:0]               i_wdata,
  input  logic                              i_pop,
  output logic [gp_width-1:0]               o_rdata,
  output logic                              o_full,
  output logic                              o_empty,
  output logic [f_clog2(gp_depth):0]        o_level
);

  localparam int lp_aw = (f_clog2(gp_depth) < 1) ? 1 : f_clog2(gp_depth);
  localparam int lp_lw = f_clog2(gp_depth) + 1;

  logic [gp_width-1:0] r_mem [gp_depth];
  logic [lp_aw-1:0]    r_wptr;
  logic [lp_aw-1:0]    r_rptr;
  logic [lp_lw-1:0]    r_level;
  logic                w_wr;
  logic                w_rd;

  // A write is taken when space exists or the head leaves in the same cycle.
  assign w_rd    = i_pop & ~o_empty;
  assign w_wr    = i_push & (~o_full | w_rd);
  assign o_full  = (r_level == lp_lw'(gp_depth));
  assign o_empty = (r_level == {lp_lw{1'b0}});
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rptr];

  // Storage, pointers and occupancy; reset empties the FIFO.
  always_ff @(posedge i_clk) begin
    if (!i_rst_an) begin
      for (int i = 0; i < gp_depth; i++) begin
        r_mem[i] <= {gp_width{1'b0}};
      end
      r_wptr  <= {lp_aw{1'b0}};
      r_rptr  <= {lp_aw{1'b0}};
      r_level <= {lp_lw{1'b0}};
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + lp_aw'(1);
      end
      if (w_rd) begin
        r_rptr <= r_rptr + lp_aw'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + lp_lw'(1);
        2'b01:   r_level <= r_level - lp_lw'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/filt_ppi_ctrl.sv
// -----------------------------------------------------------------------------
// filt_ppi_ctrl
// Sequencing controller for the polyphase interpolation FIR datapath, running
// on the output-rate clock with a clock-enable instead of a divided clock.
// Input samples arrive over valid/ready into a small FIFO; one sample is
// issued to the multiply-add bank per frame of L output cycles, with a
// one-cycle load strobe on the first phase of each frame. The commutator phase
// index advances once per enabled cycle. Starvation at a frame boundary sets a
// sticky underflow flag.
//
// Optional build macro FILT_PPI_CTRL_ZERO_STUFF_EN: when defined, a starved
// frame boundary loads a zero sample and keeps running instead of stalling.
//
// Ports:
//   i_clk        fast clock
//   i_rst_an     synchronous active-low reset
//   i_ena        global enable; low freezes all state
//   i_data       input sample, i_valid qualifies it, o_ready accepts it
//   o_data       sample presented to the datapath (held between loads)
//   o_load       one-cycle strobe: o_data is new this cycle
//   o_phase      commutator phase index, o_phase_vld marks it meaningful
//   o_underflow  sticky starvation flag
//   o_level      FIFO occupancy
// -----------------------------------------------------------------------------
module filt_ppi_ctrl
  import filt_ppi_pkg::*;
#(
  parameter int gp_idata_width          = 16,
  parameter int gp_interpolation_factor = 4,
  parameter int gp_fifo_depth           = 4,
  parameter int gp_comm_ccw             = 0
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst_an,
  input  logic                                        i_ena,
  input  logic [gp_idata_width-1:0]                   i_data,
  input  logic                                        i_valid,
  output logic                                        o_ready,
  output logic [gp_idata_width-1:0]                   o_data,
  output logic                                        o_load,
  output logic [f_clog2(gp_interpolation_factor)-1:0] o_phase,
  output logic                                        o_phase_vld,
  output logic                                        o_underflow,
  output logic [f_clog2(gp_fifo_depth):0]             o_level
);

  localparam int lp_phase_w = f_clog2(gp_interpolation_factor);
  localparam int lp_level_w = f_clog2(gp_fifo_depth) + 1;
  localparam logic [lp_phase_w-1:0] lp_first =
    lp_phase_w'(f_first_phase(gp_interpolation_factor, gp_comm_ccw));
  localparam logic [lp_phase_w-1:0] lp_last =
    lp_phase_w'(f_last_phase(gp_interpolation_factor, gp_comm_ccw));

  ppi_state_e                r_state;
  ppi_state_e                w_state_nxt;
  logic [lp_phase_w-1:0]     r_phase;
  logic [lp_phase_w-1:0]     w_phase_nxt;
  logic [lp_phase_w-1:0]     w_phase_step;
  logic [gp_idata_width-1:0] r_data;
  logic [gp_idata_width-1:0] w_data_nxt;
  logic                      r_load;
  logic                      w_load_nxt;
  logic                      r_vld;
  logic                      w_vld_nxt;
  logic                      r_uf;
  logic                      w_uf_nxt;
  logic                      r_alive;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_empty;
  logic [lp_level_w-1:0]     w_level;
  logic [gp_idata_width-1:0] w_rdata;

  // r_alive keeps o_ready low in the first cycle after any reset edge.
  assign o_ready     = i_ena & ~w_full & r_alive;
  assign w_push      = i_valid & o_ready;
  assign o_data      = r_data;
  assign o_load      = r_load & i_ena;
  assign o_phase     = r_phase;
  assign o_phase_vld = r_vld & i_ena;
  assign o_underflow = r_uf;
  assign o_level     = w_level;

  filt_ppi_ctrl_fifo #(
    .gp_width (gp_idata_width),
    .gp_depth (gp_fifo_depth)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rst_an (i_rst_an),
    .i_push   (w_push),
    .i_wdata  (i_data),
    .i_pop    (w_pop),
    .o_rdata  (w_rdata),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_level  (w_level)
  );

  // Next phase within a frame, in the configured rotation direction.
  always_comb begin
    w_phase_step = r_phase;
    if (gp_comm_ccw != 0) begin
      w_phase_step = r_phase - lp_phase_w'(1);
    end else begin
      w_phase_step = r_phase + lp_phase_w'(1);
    end
  end

  // Frame sequencing: pop at frame boundaries, strobe the load, advance phase.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_data_nxt  = r_data;
    w_load_nxt  = 1'b0;
    w_vld_nxt   = r_vld;
    w_uf_nxt    = r_uf;
    w_pop       = 1'b0;
    if (i_ena) begin
      case (r_state)
        ST_IDLE, ST_STARVE: begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_data_nxt  = w_rdata;
            w_load_nxt  = 1'b1;
            w_phase_nxt = lp_first;
            w_vld_nxt   = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            w_phase_nxt = lp_first;
            w_vld_nxt   = 1'b0;
          end
        end
        ST_RUN: begin
          w_vld_nxt = 1'b1;
          if (r_phase == lp_last) begin
            w_phase_nxt = lp_first;
            if (!w_empty) begin
              w_pop      = 1'b1;
              w_data_nxt = w_rdata;
              w_load_nxt = 1'b1;
            end else begin
              w_uf_nxt = 1'b1;
`ifdef FILT_PPI_CTRL_ZERO_STUFF_EN
              // Keep the output rate: run the next frame on a zero sample.
              w_data_nxt = {gp_idata_width{1'b0}};
              w_load_nxt = 1'b1;
`else
              w_vld_nxt   = 1'b0;
              w_state_nxt = ST_STARVE;
`endif
            end
          end else begin
            w_phase_nxt = w_phase_step;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_phase_nxt = lp_first;
          w_vld_nxt   = 1'b0;
        end
      endcase
    end else begin
      // Frozen: everything holds, including a pending load strobe.
      w_load_nxt = r_load;
    end
  end

  // Controller state and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_an) begin
      r_state <= ST_IDLE;
      r_phase <= lp_first;
      r_data  <= {gp_idata_width{1'b0}};
      r_load  <= 1'b0;
      r_vld   <= 1'b0;
      r_uf    <= 1'b0;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_data  <= w_data_nxt;
      r_load  <= w_load_nxt;
      r_vld   <= w_vld_nxt;
      r_uf    <= w_uf_nxt;
      r_alive <= 1'b1;
    end
  end

endmodule
